glyph_fetch: RTL and testbench



---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_timing.sv | 40 ++++
 rtl/glyph_fetch.sv | 85 ++++++++
 tb/tb_glyph_fetch.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing, text-tile geometry and RGB332 layout.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_ACTIVE = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int TILE_COLS = 80;
  localparam int TILE_ROWS = 60;
  localparam int TILE_W = 8;
  localparam int CW = 10;
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;
  // trow*80 as two shifts so no multiplier is inferred
  function automatic logic [13:0] tile_addr(input logic [13:0] base, input logic [6:0] trow, input logic [6:0] tcol);
    return base + ({7'd0, trow} << 6) + ({7'd0, trow} << 4) + {7'd0, tcol};
  endfunction
endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel/line counters with combinational sync and active decode.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP = vga_pkg::V_BP
) (
  input  logic          clk,
  input  logic          reset,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic [CW-1:0] vnext,
  output logic          active,
  output logic          hs,
  output logic          vs
);
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  logic hwrap;
  assign hwrap = hcount == CW'(HT - 1);
  assign vnext = (vcount == CW'(VT - 1)) ? '0 : vcount + 1'b1;
  assign active = hcount < CW'(H_ACTIVE) && vcount < CW'(V_ACTIVE);
  assign hs = !(hcount >= CW'(H_ACTIVE + H_FP) && hcount < CW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs = !(vcount >= CW'(V_ACTIVE + V_FP) && vcount < CW'(V_ACTIVE + V_FP + V_SYNC));
  always_ff @(posedge clk) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else begin
      hcount <= hwrap ? '0 : hcount + 1'b1;
      if (hwrap) vcount <= vnext;
    end
  end
endmodule

// File: rtl/glyph_fetch.sv
// glyph_fetch: text-mode VGA front end fetching tile-map and glyph words one tile ahead of the beam.
module glyph_fetch
  import vga_pkg::*;
#(
  parameter logic [13:0] MAP_BASE = 14'h2400,
  parameter logic [13:0] GLYPH_BASE = 14'h3800,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP = vga_pkg::V_BP
) (
  input  logic        clk,
  input  logic        reset,
  output logic [13:0] glyphAdd,
  input  logic [15:0] glyphData,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  rgb,
  output logic        video_on
);
  localparam int H_T = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int COLS = (H_ACTIVE / TILE_W < TILE_COLS) ? H_ACTIVE / TILE_W : TILE_COLS;
  localparam int ROWS = (V_ACTIVE / TILE_W < TILE_ROWS) ? V_ACTIVE / TILE_W : TILE_ROWS;
  logic [CW-1:0] hcount, vcount, vnext, fline;
  logic active, hs, vs, last_win, fetch_ok;
  logic [6:0] win, tcol, trow;
  logic [2:0] p, prow;
  logic [15:0] map_word;
  logic [7:0] shift, next_bits;
  rgb332_t fg, next_fg;
  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk),
    .reset(reset),
    .hcount(hcount),
    .vcount(vcount),
    .vnext(vnext),
    .active(active),
    .hs(hs),
    .vs(vs)
  );
  // the last 8-pixel window of a line prefetches column 0 of the following line
  assign win = hcount[CW-1:3];
  assign p = hcount[2:0];
  assign last_win = win == 7'(H_T / TILE_W - 1);
  assign fline = last_win ? vnext : vcount;
  assign trow = fline[CW-1:3];
  assign prow = fline[2:0];
  assign tcol = last_win ? '0 : win + 7'd1;
  assign fetch_ok = tcol < 7'(COLS) && trow < 7'(ROWS);
  always_ff @(posedge clk) begin
    if (reset) begin
      glyphAdd <= '0;
      map_word <= '0;
      next_bits <= '0;
      next_fg <= '0;
      shift <= '0;
      fg <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      video_on <= 1'b0;
      rgb <= '0;
    end else begin
      hsync <= hs;
      vsync <= vs;
      video_on <= active;
      rgb <= (active && shift[7]) ? fg : rgb332_t'(8'h00);
      shift <= (p == 3'd7) ? next_bits : {shift[6:0], 1'b0};
      if (p == 3'd7) fg <= next_fg;
      if (p == 3'd0 && fetch_ok) glyphAdd <= tile_addr(MAP_BASE, trow, tcol);
      if (p == 3'd2) map_word <= glyphData;
      if (p == 3'd3 && fetch_ok) glyphAdd <= GLYPH_BASE + {3'b000, map_word[7:0], prow};
      if (p == 3'd5) begin
        next_bits <= fetch_ok ? glyphData[7:0] : 8'h00;
        next_fg <= rgb332_t'(map_word[15:8]);
      end
    end
  end
endmodule

// File: tb/tb_glyph_fetch.sv
// tb_glyph_fetch: directed checks of sync timing, fetch addresses and rendered pixels on a short-frame build.
module tb_glyph_fetch;
  localparam int VA = 24;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int LINE = 800;
  localparam int FRAME = LINE * (VA + VF + VS + VB);
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [13:0] glyphAdd;
  logic [15:0] glyphData = 16'h0000;
  logic hsync, vsync, video_on;
  logic [7:0] rgb;
  logic [15:0] mem [0:16383];
  int n = 0;
  int vecs = 0;
  int errs = 0;
  bit mon_en = 1'b0;
  logic hs_q = 1'b1;
  logic vs_q = 1'b1;
  int hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$];
  int von[4];
  logic [7:0] row_exp [8] = '{8'h1C, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h1C};
  glyph_fetch #(.V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut (
    .clk(clk),
    .reset(reset),
    .glyphAdd(glyphAdd),
    .glyphData(glyphData),
    .hsync(hsync),
    .vsync(vsync),
    .rgb(rgb),
    .video_on(video_on)
  );
  always #20 clk = ~clk;
  always @(posedge clk) glyphData <= mem[glyphAdd];
  always @(negedge clk) begin
    if (mon_en && n > 0) begin
      if (!hsync && hs_q) hs_fall.push_back(n);
      if (hsync && !hs_q) hs_rise.push_back(n);
      if (!vsync && vs_q) vs_fall.push_back(n);
      if (vsync && !vs_q) vs_rise.push_back(n);
      if (video_on && (n - 1) / FRAME < 4) von[(n - 1) / FRAME] = von[(n - 1) / FRAME] + 1;
      hs_q = hsync;
      vs_q = vsync;
    end
  end
  task automatic tick();
    @(posedge clk);
    n = n + 1;
    @(negedge clk);
  endtask
  task automatic adv(input int t);
    while (n < t) tick();
  endtask
  function automatic int pix(input int f, input int y, input int x);
    return f * FRAME + y * LINE + x + 1;
  endfunction
  function automatic int pos(input int f, input int y, input int x);
    return f * FRAME + y * LINE + x;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs = vecs + 1;
    assert (obs === exp) else begin
      errs = errs + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic restart();
    hs_fall.delete();
    hs_rise.delete();
    vs_fall.delete();
    vs_rise.delete();
    for (int i = 0; i < 4; i++) von[i] = 0;
    hs_q = 1'b1;
    vs_q = 1'b1;
    n = 0;
    mon_en = 1'b1;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_hsync"}, 32'(hsync), 32'd1);
    chk({tag, "_vsync"}, 32'(vsync), 32'd1);
    chk({tag, "_video_on"}, 32'(video_on), 32'd0);
    chk({tag, "_rgb"}, 32'(rgb), 32'd0);
    chk({tag, "_glyphAdd"}, 32'(glyphAdd), 32'd0);
  endtask
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;
    mem[14'h2400] = 16'h03C3;
    mem[14'h3E18] = 16'h00FF;
    mem[14'h2401] = 16'h1CAA;
    mem[14'h3D50] = 16'h00A5;
    mem[14'h24A0] = 16'hE041;
    mem[14'h3A0A] = 16'h0081;
    mem[14'h24EF] = 16'hFFFF;
    mem[14'h3FFF] = 16'h00FF;
    repeat (3) tick();
    chk_reset("por");
    reset = 1'b0;
    restart();
    adv(pos(0, 20, 300));
    chk("seg1_hs_first_fall", 32'(hs_fall[0]), 32'd657);
    chk("seg1_video_on_mid", 32'(video_on), 32'd1);
    mon_en = 1'b0;
    reset = 1'b1;
    tick();
    chk_reset("mid");
    reset = 1'b0;
    restart();
    adv(pix(0, 0, 0));
    chk("f0_px0_no_prefetch", 32'(rgb), 32'h00);
    adv(pos(0, 17, 793));
    chk("trace_map_addr", 32'(glyphAdd), 32'h24A0);
    adv(pos(0, 17, 796));
    chk("trace_glyph_addr", 32'(glyphAdd), 32'h3A0A);
    adv(pix(0, 18, 0));
    chk("l18_px0", 32'(rgb), 32'hE0);
    adv(pix(0, 18, 1));
    chk("l18_px1", 32'(rgb), 32'h00);
    adv(pix(0, 18, 7));
    chk("l18_px7", 32'(rgb), 32'hE0);
    adv(pos(0, 23, 628));
    chk("edge_glyph_addr", 32'(glyphAdd), 32'h3FFF);
    adv(pix(0, 23, 632));
    chk("edge_px632", 32'(rgb), 32'hFF);
    adv(pix(0, 23, 635));
    chk("edge_px635", 32'(rgb), 32'hFF);
    adv(pix(0, 23, 639));
    chk("edge_px639", 32'(rgb), 32'hFF);
    adv(pix(0, 23, 640));
    chk("edge_px640", 32'(rgb), 32'h00);
    chk("edge_px640_von", 32'(video_on), 32'd0);
    adv(pos(0, 23, 700));
    chk("hold_h700", 32'(glyphAdd), 32'h3FFF);
    adv(pos(0, 23, 799));
    chk("hold_h799", 32'(glyphAdd), 32'h3FFF);
    adv(pos(0, 25, 400));
    chk("hold_vblank", 32'(glyphAdd), 32'h3FFF);
    adv(pos(0, VA + VF + VS + VB - 1, 793));
    chk("wrap_prefetch_addr", 32'(glyphAdd), 32'h2400);
    adv(pix(1, 0, 0));
    chk("f1_px0_prefetched", 32'(rgb), 32'h03);
    for (int i = 0; i < 8; i++) begin
      adv(pix(1, 0, 8 + i));
      chk($sformatf("f1_px%0d", 8 + i), 32'(rgb), 32'(row_exp[i]));
    end
    adv(pix(2, 0, 0));
    chk("hs_first_fall", 32'(hs_fall[0]), 32'd657);
    chk("hs_low", 32'(hs_rise[0] - hs_fall[0]), 32'd96);
    chk("hs_period", 32'(hs_fall[1] - hs_fall[0]), 32'd800);
    chk("vs_first_fall", 32'(vs_fall[0]), 32'((VA + VF) * LINE + 1));
    chk("vs_low", 32'(vs_rise[0] - vs_fall[0]), 32'd1600);
    chk("vs_period", 32'(vs_fall[1] - vs_fall[0]), 32'(FRAME));
    chk("von_frame0", 32'(von[0]), 32'(640 * VA));
    chk("von_frame1", 32'(von[1]), 32'(640 * VA));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
